wb_regfile: RTL and testbench

- Write-back end of the MEM/WB interface: consumes the MEM/WB pipeline register outputs, selects the write-back data, and commits it to a 32x32 architectural register file.
- Provides two combinational read ports for ID, with same-cycle write-to-read bypass, so the ID stage needs no separate WB-to-ID forwarding.
- Keeps a retired-write counter for debug and performance readout.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/wb_read_port.sv | 25 ++
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the write-back stage, the control unit and MEM_WBReg.
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_read_port.sv
// One combinational register-file read port. Register 0 reads as zero, and a
// write committing this cycle is bypassed straight to the reader.
module wb_read_port #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] wn,
    input  logic          fire,
    input  logic [DW-1:0] wd,
    input  logic [DW-1:0] stored,
    output logic [DW-1:0] rd
);
    import cpu_pkg::REG_ZERO;

    always_comb begin
        rd = stored;
        if (ra == AW'(REG_ZERO)) begin
            rd = '0;
        end else if (fire && (wn == ra)) begin
            rd = wd;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects MEM/WB data, commits it to the 32x32 register
// file, serves two bypassed read ports and counts retired writes.
module wb_regfile #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic            RegWrite_in,
    input  logic            MemtoReg_in,
    input  logic [DW-1:0]   RD_in,
    input  logic [DW-1:0]   ALU_in,
    input  logic [AW-1:0]   WN_in,
    input  logic [AW-1:0]   RA1,
    input  logic [AW-1:0]   RA2,
    output logic [DW-1:0]   RD1,
    output logic [DW-1:0]   RD2,
    output logic [DW-1:0]   WD_out,
    output logic            wb_fire,
    output logic [CNTW-1:0] retire_cnt
);
    import cpu_pkg::REG_ZERO;
    import cpu_pkg::WB_SRC_MEM;

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] regs [0:DEPTH-1];

    assign WD_out  = (MemtoReg_in == WB_SRC_MEM) ? RD_in : ALU_in;
    assign wb_fire = wb_en & RegWrite_in & (WN_in != AW'(REG_ZERO));

    // Entry 0 is never written, so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            retire_cnt <= '0;
        end else if (wb_fire) begin
            regs[WN_in] <= WD_out;
            retire_cnt  <= retire_cnt + CNTW'(1);
        end
    end

    wb_read_port #(.DW(DW), .AW(AW)) u_port1 (
        .ra     (RA1),
        .wn     (WN_in),
        .fire   (wb_fire),
        .wd     (WD_out),
        .stored (regs[RA1]),
        .rd     (RD1)
    );

    wb_read_port #(.DW(DW), .AW(AW)) u_port2 (
        .ra     (RA2),
        .wn     (WN_in),
        .fire   (wb_fire),
        .wd     (WD_out),
        .stored (regs[RA2]),
        .rd     (RD2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_wb_regfile;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CNTW = 4;

    localparam int S_RD1  = 0;
    localparam int S_RD2  = 1;
    localparam int S_WD   = 2;
    localparam int S_FIRE = 3;
    localparam int S_CNT  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_en;
    logic            RegWrite_in;
    logic            MemtoReg_in;
    logic [DW-1:0]   RD_in;
    logic [DW-1:0]   ALU_in;
    logic [AW-1:0]   WN_in;
    logic [AW-1:0]   RA1;
    logic [AW-1:0]   RA2;
    logic [DW-1:0]   RD1;
    logic [DW-1:0]   RD2;
    logic [DW-1:0]   WD_out;
    logic            wb_fire;
    logic [CNTW-1:0] retire_cnt;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    wb_regfile #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .RegWrite_in (RegWrite_in),
        .MemtoReg_in (MemtoReg_in),
        .RD_in       (RD_in),
        .ALU_in      (ALU_in),
        .WN_in       (WN_in),
        .RA1         (RA1),
        .RA2         (RA2),
        .RD1         (RD1),
        .RD2         (RD2),
        .WD_out      (WD_out),
        .wb_fire     (wb_fire),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dut_sig(input int s);
        case (s)
            S_RD1:   return RD1;
            S_RD2:   return RD2;
            S_WD:    return WD_out;
            S_FIRE:  return {31'b0, wb_fire};
            default: return 32'(retire_cnt);
        endcase
    endfunction

    // Monitor: every queued expectation belongs to the current cycle's inputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = q.pop_front();
            act = dut_sig(e.sig);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rw, input logic m2r,
                         input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wn);
        wb_en       = en;
        RegWrite_in = rw;
        MemtoReg_in = m2r;
        RD_in       = rd;
        ALU_in      = alu;
        WN_in       = wn;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        rst = 1'b0;
        RA1 = 5'd5;
        RA2 = 5'd0;
        idle();
        step();
        step();
        chk("reset_cnt", S_CNT, 32'd0);
        chk("reset_rd1", S_RD1, 32'd0);
        rst = 1'b1;
        step();

        // reset clears a written register
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5);
        chk("r5_fire", S_FIRE, 32'd1);
        chk("r5_wd", S_WD, 32'hDEADBEEF);
        chk("r5_bypass", S_RD1, 32'hDEADBEEF);
        step();
        idle();
        chk("r5_stored", S_RD1, 32'hDEADBEEF);
        chk("r5_cnt", S_CNT, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("r5_cleared", S_RD1, 32'd0);
        chk("r5_cnt_cleared", S_CNT, 32'd0);
        step();

        // write-data mux, memory then ALU source
        drive(1'b1, 1'b1, 1'b1, 32'h11112222, 32'h33334444, 5'd7);
        RA2 = 5'd7;
        chk("mux_mem_wd", S_WD, 32'h11112222);
        step();
        idle();
        chk("mux_mem_rd2", S_RD2, 32'h11112222);
        chk("mux_mem_cnt", S_CNT, 32'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h11112222, 32'h33334444, 5'd7);
        chk("mux_alu_wd", S_WD, 32'h33334444);
        step();
        idle();
        chk("mux_alu_rd2", S_RD2, 32'h33334444);
        chk("mux_alu_cnt", S_CNT, 32'd2);
        step();

        // bypass on both ports, and a non-matching port reads storage
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h10101010, 5'd10);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hCAFE0001, 5'd9);
        RA1 = 5'd9;
        RA2 = 5'd9;
        chk("byp_rd1", S_RD1, 32'hCAFE0001);
        chk("byp_rd2", S_RD2, 32'hCAFE0001);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hCAFE0002, 5'd9);
        RA1 = 5'd10;
        chk("byp_old_r10", S_RD1, 32'h10101010);
        chk("byp_rd2_again", S_RD2, 32'hCAFE0002);
        step();
        idle();
        chk("byp_stored_r9", S_RD2, 32'hCAFE0002);
        chk("byp_cnt", S_CNT, 32'd5);
        step();

        // register 0 is never written
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
        RA1 = 5'd0;
        chk("r0_fire", S_FIRE, 32'd0);
        chk("r0_rd1_during", S_RD1, 32'd0);
        chk("r0_wd", S_WD, 32'hFFFFFFFF);
        step();
        idle();
        chk("r0_rd1_after", S_RD1, 32'd0);
        chk("r0_cnt", S_CNT, 32'd5);
        step();

        // stall holds a write for three cycles, then commits once
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000ABCD, 5'd3);
        RA1 = 5'd3;
        for (int i = 0; i < 3; i++) begin
            chk("stall_rd1", S_RD1, 32'd0);
            chk("stall_fire", S_FIRE, 32'd0);
            step();
        end
        chk("stall_cnt", S_CNT, 32'd5);
        wb_en = 1'b1;
        chk("stall_release_byp", S_RD1, 32'h0000ABCD);
        step();
        idle();
        chk("stall_stored", S_RD1, 32'h0000ABCD);
        chk("stall_cnt_once", S_CNT, 32'd6);
        step();

        // reset wins over a write on the same edge
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h00000044, 5'd4);
        RA1 = 5'd4;
        RA2 = 5'd3;
        rst = 1'b0;
        chk("rstpri_wd_follows", S_WD, 32'h00000044);
        chk("rstpri_fire_follows", S_FIRE, 32'd1);
        step();
        idle();
        rst = 1'b1;
        chk("rstpri_r4", S_RD1, 32'd0);
        chk("rstpri_r3", S_RD2, 32'd0);
        chk("rstpri_cnt", S_CNT, 32'd0);
        step();

        // fifteen commits reach all-ones, the sixteenth wraps to zero
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h01010101 * (i + 1), 5'(i + 1));
            step();
        end
        idle();
        chk("wrap_full", S_CNT, 32'd15);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h5A5A5A5A, 5'd20);
        step();
        idle();
        RA1 = 5'd2;
        RA2 = 5'd20;
        chk("wrap_zero", S_CNT, 32'd0);
        chk("wrap_r2", S_RD1, 32'h02020202);
        chk("wrap_r20", S_RD2, 32'h5A5A5A5A);
        step();

        // RegWrite low: no commit, no bypass, no count
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h00000777, 5'd6);
        RA1 = 5'd6;
        chk("norw_fire", S_FIRE, 32'd0);
        chk("norw_rd1", S_RD1, 32'h06060606);
        step();
        idle();
        chk("norw_r6", S_RD1, 32'h06060606);
        chk("norw_cnt", S_CNT, 32'd0);
        step();

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            step();
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
